icache_tag_ctrl: RTL and testbench
==================================

ICACHE_TAG_CTRL -- requirements
Module: icache_tag_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_ON_RESET, default 1, meaning invalidate all 256 tag entries after reset.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk_i input 1 rising-edge clock; rst_i input 1 asynchronous active-low reset.
REQ-003 SHALL have req_valid_i input 1, fetch lookup request.
REQ-004 SHALL have req_addr_i input 32, fetch address: tag [31:13], index [12:5], offset [4:0].
REQ-005 SHALL have req_accept_o output 1, request taken this cycle.
REQ-006 SHALL have resp_valid_o output 1, lookup result valid.
REQ-007 SHALL have hit_o output 1, result was a hit.
REQ-008 SHALL have miss_o output 1, result was a refilled miss.
REQ-009 SHALL have refill_req_o output 1, line refill request.
REQ-010 SHALL have refill_addr_o output 32, line-aligned refill address.
REQ-011 SHALL have refill_ack_i input 1, line data written.
REQ-012 SHALL have flush_i input 1, invalidate-all request.
REQ-013 SHALL have flush_busy_o output 1, flush pending or active.
REQ-014 SHALL have tag_addr_o output 8, tag RAM index.
REQ-015 SHALL have tag_data_o output 20, tag RAM write data as {valid, tag[18:0]}.
REQ-016 SHALL have tag_wr_o output 1, tag RAM write enable.
REQ-017 SHALL have tag_data_i input 20, tag RAM read data, valid one cycle after the address.

Function
REQ-018 SHALL implement the FSM states FLUSH, IDLE, LOOKUP, REFILL and UPDATE.
REQ-019 FLUSH SHALL write tag_data_o=0, tag_wr_o=1 at tag_addr_o=flush counter 0..255, one entry per cycle, then enter IDLE after entry 255; counter SHALL wrap to 0.
REQ-020 In IDLE, req_accept_o SHALL equal req_valid_i & ~flush_pending; tag_addr_o SHALL be req_addr_i[12:5] combinationally; on accept, the address SHALL be captured and the FSM SHALL enter LOOKUP.
REQ-021 In LOOKUP, hit SHALL be tag_data_i[19] & (tag_data_i[18:0]==captured[31:13]); on hit, resp_valid_o=1 and hit_o=1 for one cycle, then IDLE.
REQ-022 On a LOOKUP miss, the FSM SHALL enter REFILL; refill_req_o SHALL be held high with refill_addr_o={captured[31:5],5'b0} until the refill_ack_i cycle, inclusive.
REQ-023 On refill_ack_i in REFILL, the FSM SHALL enter UPDATE.
REQ-024 UPDATE SHALL assert tag_wr_o=1, tag_data_o={1'b1,captured[31:13]}, tag_addr_o=captured[12:5], resp_valid_o=1 and miss_o=1 for one cycle, then IDLE.
REQ-025 Outside FLUSH and IDLE, tag_addr_o SHALL be captured[12:5].
REQ-026 Throughput SHALL be one hit per 2 cycles; hit latency SHALL be 1 cycle after accept.
REQ-027 flush_i in any state SHALL set flush_pending; the flush SHALL start only from IDLE, and flush SHALL take priority over req_valid_i in the same cycle.
REQ-028 flush_pending SHALL clear on FLUSH entry.
REQ-029 flush_busy_o SHALL be flush_pending | (state==FLUSH).
REQ-030 A flush_i during an in-flight miss SHALL NOT abort REFILL/UPDATE; the line write SHALL complete, then the flush SHALL clear it.
REQ-031 refill_ack_i outside REFILL SHALL be ignored.
REQ-032 hit_o, miss_o and resp_valid_o SHALL never be high with hit_o & miss_o together.

Reset
REQ-033 Reset assertion SHALL immediately set state=FLUSH (IDLE if FLUSH_ON_RESET=0), flush counter=0, flush_pending=0 and captured address=0.
REQ-034 During reset, all outputs SHALL be 0 except tag_wr_o and flush_busy_o, which SHALL be 1 when FLUSH_ON_RESET=1.
REQ-035 Reset mid-refill SHALL drop refill_req_o asynchronously; no tag write SHALL occur.

Structure
REQ-036 Package icache_pkg SHALL hold the tag/index/offset bit positions, the tag entry width (20), the valid bit position (19) and the FSM state enum.
REQ-037 The block SHALL contain no sub-module; the tag RAM SHALL be instantiated beside it by the parent cache.

Verification
REQ-038 Reset release with FLUSH_ON_RESET=1 -> 256 consecutive writes of 0 at addresses 0..255, flush_busy_o low and req_accept_o possible on cycle 257.
REQ-039 Request 0x0000_2040 after flush -> miss, refill_addr_o=0x0000_2040; ack after 5 cycles -> write {1,0x00001} at index 0x02, miss_o pulse.
REQ-040 Repeat request 0x0000_2044 -> hit_o=1 one cycle after accept, no refill_req_o.
REQ-041 Request 0x0000_4040 (same index, tag 0x00002) -> miss and tag overwrite; then 0x0000_2040 -> miss again.
REQ-042 Assert flush_i and req_valid_i together in IDLE -> req_accept_o=0, FLUSH runs, and the subsequent lookup misses.
REQ-043 Pull rst_i low during REFILL -> refill_req_o=0 immediately, FSM restarts in FLUSH.

Source files
------------

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - Address field positions, tag entry layout and FSM states for the icache tag controller
package icache_pkg;

  localparam int TAG_MSB   = 31;
  localparam int TAG_LSB   = 13;
  localparam int IDX_MSB   = 12;
  localparam int IDX_LSB   = 5;
  localparam int OFF_MSB   = 4;
  localparam int OFF_LSB   = 0;

  localparam int TAG_W     = TAG_MSB - TAG_LSB + 1;
  localparam int IDX_W     = IDX_MSB - IDX_LSB + 1;
  localparam int ENTRY_W   = 20;
  localparam int VALID_BIT = 19;

  typedef enum logic [2:0] {
    ST_FLUSH  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_REFILL = 3'd3,
    ST_UPDATE = 3'd4
  } state_e;

endpackage

// File: rtl/icache_tag_ctrl.sv
// rtl/icache_tag_ctrl.sv - Instruction cache tag lookup, refill sequencing and invalidate-all controller
module icache_tag_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned FLUSH_ON_RESET = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  input  logic [31:0]         req_addr_i,
  output logic                req_accept_o,
  output logic                resp_valid_o,
  output logic                hit_o,
  output logic                miss_o,
  output logic                refill_req_o,
  output logic [31:0]         refill_addr_o,
  input  logic                refill_ack_i,
  input  logic                flush_i,
  output logic                flush_busy_o,
  output logic [IDX_W-1:0]    tag_addr_o,
  output logic [ENTRY_W-1:0]  tag_data_o,
  output logic                tag_wr_o,
  input  logic [ENTRY_W-1:0]  tag_data_i
);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       flush_cnt_q;
  logic                   flush_pending_q;
  logic [TAG_MSB:IDX_LSB] cap_q;
  logic                   flush_req;
  logic                   lookup_hit;
  logic                   unused_offset;

  // A flush arriving in the same IDLE cycle as a request must already block it.
  assign flush_req     = flush_pending_q | flush_i;
  assign lookup_hit    = tag_data_i[VALID_BIT] &
                         (tag_data_i[TAG_W-1:0] == cap_q[TAG_MSB:TAG_LSB]);
  assign flush_busy_o  = flush_pending_q | (state_q == ST_FLUSH);
  assign unused_offset = ^req_addr_i[OFF_MSB:OFF_LSB];

  always_comb begin
    state_d       = state_q;
    req_accept_o  = 1'b0;
    resp_valid_o  = 1'b0;
    hit_o         = 1'b0;
    miss_o        = 1'b0;
    refill_req_o  = 1'b0;
    refill_addr_o = 32'd0;
    tag_addr_o    = cap_q[IDX_MSB:IDX_LSB];
    tag_data_o    = '0;
    tag_wr_o      = 1'b0;
    case (state_q)
      ST_FLUSH: begin
        tag_addr_o = flush_cnt_q;
        tag_wr_o   = 1'b1;
        if (flush_cnt_q == {IDX_W{1'b1}}) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        tag_addr_o = req_addr_i[IDX_MSB:IDX_LSB];
        if (flush_req) begin
          state_d = ST_FLUSH;
        end else if (req_valid_i) begin
          req_accept_o = 1'b1;
          state_d      = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (lookup_hit) begin
          resp_valid_o = 1'b1;
          hit_o        = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        refill_req_o  = 1'b1;
        refill_addr_o = {cap_q, {IDX_LSB{1'b0}}};
        if (refill_ack_i) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        tag_wr_o     = 1'b1;
        tag_data_o   = {1'b1, cap_q[TAG_MSB:TAG_LSB]};
        resp_valid_o = 1'b1;
        miss_o       = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q         <= (FLUSH_ON_RESET != 0) ? ST_FLUSH : ST_IDLE;
      flush_cnt_q     <= '0;
      flush_pending_q <= 1'b0;
      cap_q           <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FLUSH) flush_cnt_q <= flush_cnt_q + 1'b1;
      if (state_q == ST_IDLE && state_d == ST_FLUSH) flush_pending_q <= 1'b0;
      else if (flush_i)                              flush_pending_q <= 1'b1;
      if (req_accept_o) cap_q <= req_addr_i[TAG_MSB:IDX_LSB];
    end
  end

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// tb/tb_icache_tag_ctrl.sv - Self-checking bench for icache_tag_ctrl with a tag RAM and cache-contents model
module tb_icache_tag_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic [31:0] req_addr_i = 32'd0;
  logic        refill_ack_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [19:0] tag_data_i = 20'd0;
  logic        req_accept_o, resp_valid_o, hit_o, miss_o, refill_req_o;
  logic [31:0] refill_addr_o;
  logic        flush_busy_o, tag_wr_o;
  logic [7:0]  tag_addr_o;
  logic [19:0] tag_data_o;

  icache_tag_ctrl #(.FLUSH_ON_RESET(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_accept_o(req_accept_o),
    .resp_valid_o(resp_valid_o), .hit_o(hit_o), .miss_o(miss_o),
    .refill_req_o(refill_req_o), .refill_addr_o(refill_addr_o), .refill_ack_i(refill_ack_i),
    .flush_i(flush_i), .flush_busy_o(flush_busy_o),
    .tag_addr_o(tag_addr_o), .tag_data_o(tag_data_o), .tag_wr_o(tag_wr_o), .tag_data_i(tag_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Tag RAM beside the controller: synchronous write, one-cycle read latency.
  logic [19:0] ram [256];
  always @(posedge clk_i) begin
    if (tag_wr_o) ram[tag_addr_o] <= tag_data_o;
    tag_data_i <= ram[tag_addr_o];
  end

  // Cache contents as the specification describes them: valid bit and tag per line.
  bit          mv [256];
  logic [18:0] mt [256];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) mv[i] = 1'b0;
  endtask

  task automatic wait_flush(output int n);
    n = 0;
    while (flush_busy_o && n < 400) begin
      chk("flush_no_accept", req_accept_o, 1'b0);
      cyc();
      n++;
    end
    chk("flush_done", flush_busy_o, 1'b0);
    model_clear();
  endtask

  task automatic lookup(input logic [31:0] a, input int dly, input bit flush_mid);
    logic [7:0]  idx;
    logic [18:0] tg;
    bit          exp_hit;
    int          n;
    idx = a[12:5];
    tg  = a[31:13];
    exp_hit = mv[idx] && (mt[idx] == tg);
    req_valid_i = 1'b1;
    req_addr_i  = a;
    #1;
    chk("accept", req_accept_o, 1'b1);
    chk("idle_tag_addr", tag_addr_o, idx);
    cyc();
    req_valid_i = 1'b0;
    req_addr_i  = $urandom;
    chk("hit", hit_o, exp_hit);
    chk("resp_valid_lookup", resp_valid_o, exp_hit);
    chk("miss_in_lookup", miss_o, 1'b0);
    chk("refill_in_lookup", refill_req_o, 1'b0);
    if (exp_hit) begin
      cyc();
      return;
    end
    cyc();
    for (int i = 0; i < dly; i++) begin
      chk("refill_req", refill_req_o, 1'b1);
      chk("refill_addr", refill_addr_o, {a[31:5], 5'b0});
      chk("refill_no_resp", resp_valid_o, 1'b0);
      if (flush_mid && i == 0) flush_i = 1'b1;
      cyc();
      flush_i = 1'b0;
      if (flush_mid && i == 0) chk("flush_busy_mid_refill", flush_busy_o, 1'b1);
    end
    refill_ack_i = 1'b1;
    #1;
    chk("refill_req_at_ack", refill_req_o, 1'b1);
    cyc();
    refill_ack_i = 1'b0;
    chk("update_wr", tag_wr_o, 1'b1);
    chk("update_data", tag_data_o, {1'b1, tg});
    chk("update_addr", tag_addr_o, idx);
    chk("update_miss", miss_o, 1'b1);
    chk("update_resp", resp_valid_o, 1'b1);
    chk("update_no_hit", hit_o, 1'b0);
    mv[idx] = 1'b1;
    mt[idx] = tg;
    cyc();
    if (flush_mid) begin
      chk("flush_after_update", flush_busy_o, 1'b1);
      wait_flush(n);
    end
  endtask

  initial begin
    int good;
    int n;
    logic [18:0] tag_pool [3];
    logic [7:0]  idx_pool [4];
    tag_pool = '{19'h00001, 19'h00002, 19'h3ABCD};
    idx_pool = '{8'h02, 8'h10, 8'h80, 8'hFF};
    foreach (ram[i]) ram[i] = 20'($urandom);

    req_valid_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_tag_wr", tag_wr_o, 1'b1);
    chk("rst_flush_busy", flush_busy_o, 1'b1);
    chk("rst_accept", req_accept_o, 1'b0);
    chk("rst_resp", {resp_valid_o, hit_o, miss_o, refill_req_o}, 4'b0);
    chk("rst_refill_addr", refill_addr_o, 32'd0);
    chk("rst_tag_addr", tag_addr_o, 8'd0);
    chk("rst_tag_data", tag_data_o, 20'd0);
    req_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;

    good = 0;
    for (int k = 0; k < 256; k++) begin
      if (tag_wr_o && tag_addr_o == 8'(k) && tag_data_o == 20'd0 && flush_busy_o) good++;
      cyc();
    end
    chk("flush_writes", good, 256);
    chk("flush_busy_after", flush_busy_o, 1'b0);
    chk("no_wr_after_flush", tag_wr_o, 1'b0);
    good = 0;
    foreach (ram[i]) if (ram[i][19]) good++;
    chk("ram_all_invalid", good, 0);
    model_clear();

    lookup(32'h0000_2040, 5, 1'b0);
    chk("ram_line_02", ram[8'h02], {1'b1, 19'h00001});
    lookup(32'h0000_2044, 0, 1'b0);
    lookup(32'h0000_4040, 2, 1'b0);
    lookup(32'h0000_2040, 1, 1'b0);

    flush_i = 1'b1;
    req_valid_i = 1'b1;
    req_addr_i = 32'h0000_2040;
    #1;
    chk("flush_priority_accept", req_accept_o, 1'b0);
    cyc();
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    chk("flush_started", tag_wr_o, 1'b1);
    chk("flush_start_addr", tag_addr_o, 8'd0);
    wait_flush(n);
    chk("flush_cycles", n, 256);
    lookup(32'h0000_2040, 0, 1'b0);

    for (int it = 0; it < 80; it++) begin
      logic [31:0] a;
      int d;
      a = {tag_pool[$urandom_range(0, 2)], idx_pool[$urandom_range(0, 3)], 5'($urandom)};
      d = $urandom_range(0, 6);
      if ($urandom_range(0, 9) == 0) begin
        refill_ack_i = 1'b1;
        cyc();
        refill_ack_i = 1'b0;
        chk("stray_ack_refill", refill_req_o, 1'b0);
        chk("stray_ack_resp", resp_valid_o, 1'b0);
      end
      if ($urandom_range(0, 19) == 0) begin
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        wait_flush(n);
      end
      lookup(a, d, (d > 0) && ($urandom_range(0, 11) == 0));
    end

    req_valid_i = 1'b1;
    req_addr_i = 32'h00AB_0AA0;
    cyc();
    req_valid_i = 1'b0;
    cyc();
    chk("pre_reset_refill", refill_req_o, 1'b1);
    rst_i = 1'b0;
    #1;
    chk("reset_drops_refill", refill_req_o, 1'b0);
    chk("reset_no_line_write", tag_data_o, 20'd0);
    chk("reset_in_flush", flush_busy_o, 1'b1);
    chk("reset_no_miss", miss_o, 1'b0);
    rst_i = 1'b1;
    wait_flush(n);
    chk("ram_55_invalid", ram[8'h55][19], 1'b0);
    lookup(32'h00AB_0AA0, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
